// File: rtl/pwm_multi_if.sv
`default_nettype none
// ============================================================================
// Module   : pwm_multi_if
// Brief    : Duty-write bus carrying one channel/duty pair per strobe.
// Revision : 1.0
// ============================================================================
interface pwm_multi_if #(
  parameter int NCH = 9,
  parameter int RES = 16
);
  localparam int CHW = (NCH > 1) ? $clog2(NCH) : 1;

  logic           wr_en;
  logic [CHW-1:0] wr_ch;
  logic [RES-1:0] wr_duty;

  modport master (output wr_en, wr_ch, wr_duty);
  modport slave  (input  wr_en, wr_ch, wr_duty);
endinterface
`default_nettype wire

// File: rtl/pwm_multi.sv
`default_nettype none
// ============================================================================
// Module   : pwm_multi
// Brief    : Shared-counter multi-channel PWM, edge/center aligned, buffered duties.
// Revision : 1.0
// ============================================================================
module pwm_multi #(
  parameter int NCH = 9,
  parameter int RES = 16
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            en,
  input  logic            mode,
  input  logic [RES-1:0]  period,
  pwm_multi_if.slave      wr_bus,
  input  logic [NCH-1:0]  polarity,
  output logic [NCH-1:0]  pwm_out,
  output logic            period_start
);
  localparam int CHW = (NCH > 1) ? $clog2(NCH) : 1;
  localparam logic [RES-1:0] ONE = RES'(1);

  typedef enum logic {
    DIR_UP   = 1'b0,
    DIR_DOWN = 1'b1
  } dir_e;

  logic [RES-1:0] cnt_q, cnt_d;
  dir_e           dir_q, dir_d;
  logic [RES-1:0] p_act_q, p_act_d;
  logic           mode_act_q, mode_act_d;
  logic [RES-1:0] pend_q [NCH];
  logic [RES-1:0] pend_d [NCH];
  logic [RES-1:0] act_q  [NCH];
  logic [RES-1:0] act_d  [NCH];
  logic [NCH-1:0] pwm_q, pwm_d;
  logic           period_start_q, period_start_d;
  logic           load;
  logic [NCH-1:0] pwm_raw;

  // Counter sequencing; the counter is bounded by p_act_q so it never wraps.
  always_comb begin
    cnt_d = cnt_q;
    dir_d = dir_q;
    if (!en) begin
      cnt_d = '0;
      dir_d = DIR_UP;
    end else if (!mode_act_q) begin
      cnt_d = (cnt_q >= p_act_q) ? '0 : cnt_q + ONE;
    end else if (p_act_q == '0) begin
      cnt_d = '0;
    end else if (dir_q == DIR_UP) begin
      if (cnt_q >= p_act_q) begin
        cnt_d = p_act_q - ONE;
        dir_d = DIR_DOWN;
      end else begin
        cnt_d = cnt_q + ONE;
      end
    end else begin
      cnt_d = (cnt_q <= ONE) ? '0 : cnt_q - ONE;
    end
    // Every period starts counting up, whatever mode the next period uses.
    if (cnt_d == '0) begin
      dir_d = DIR_UP;
    end
  end

  assign load = !en || (cnt_d == '0);

  // pend_d already holds a same-cycle write, so a load forwards it into act.
  always_comb begin
    for (int i = 0; i < NCH; i++) begin
      pend_d[i] = pend_q[i];
      if (wr_bus.wr_en && (wr_bus.wr_ch == CHW'(i))) begin
        pend_d[i] = wr_bus.wr_duty;
      end
      act_d[i] = load ? pend_d[i] : act_q[i];
    end
    p_act_d    = load ? period : p_act_q;
    mode_act_d = load ? mode   : mode_act_q;
  end

  for (genvar g = 0; g < NCH; g++) begin : g_ch
    assign pwm_raw[g] = (cnt_q < act_q[g]);
  end

  always_comb begin
    pwm_d          = en ? (pwm_raw ^ polarity) : polarity;
    period_start_d = en && (cnt_q == '0);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q          <= '0;
      dir_q          <= DIR_UP;
      p_act_q        <= '0;
      mode_act_q     <= 1'b0;
      pwm_q          <= '0;
      period_start_q <= 1'b0;
      for (int i = 0; i < NCH; i++) begin
        pend_q[i] <= '0;
        act_q[i]  <= '0;
      end
    end else begin
      cnt_q          <= cnt_d;
      dir_q          <= dir_d;
      p_act_q        <= p_act_d;
      mode_act_q     <= mode_act_d;
      pwm_q          <= pwm_d;
      period_start_q <= period_start_d;
      for (int i = 0; i < NCH; i++) begin
        pend_q[i] <= pend_d[i];
        act_q[i]  <= act_d[i];
      end
    end
  end

  assign pwm_out      = pwm_q;
  assign period_start = period_start_q;
endmodule
`default_nettype wire

// File: tb/tb_pwm_multi.sv
`default_nettype none
// ============================================================================
// Module   : tb_pwm_multi
// Brief    : Self-checking bench for pwm_multi against a period-list model.
// Revision : 1.0
// ============================================================================
module tb_pwm_multi;
  localparam int NCH = 9;
  localparam int RES = 8;

  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic           en = 1'b0;
  logic           mode = 1'b0;
  logic [RES-1:0] period = '0;
  logic [NCH-1:0] polarity = '0;
  logic [NCH-1:0] pwm_out;
  logic           period_start;

  pwm_multi_if #(.NCH(NCH), .RES(RES)) bus ();

  pwm_multi #(.NCH(NCH), .RES(RES)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .en           (en),
    .mode         (mode),
    .period       (period),
    .wr_bus       (bus),
    .polarity     (polarity),
    .pwm_out      (pwm_out),
    .period_start (period_start)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // Model: the active period is a list of counter values; a load happens
  // whenever the list is exhausted or the block is disabled.
  int             m_pend [NCH];
  int             m_act  [NCH];
  int             m_p;
  int             m_mode;
  int             m_seq [$];
  int             m_idx;
  logic [NCH-1:0] exp_pwm;
  logic           exp_ps;

  task automatic m_build();
    m_seq.delete();
    m_seq.push_back(0);
    for (int v = 1; v <= m_p; v++) m_seq.push_back(v);
    if (m_mode != 0) for (int v = m_p - 1; v >= 1; v--) m_seq.push_back(v);
    m_idx = 0;
  endtask

  task automatic m_reset();
    for (int i = 0; i < NCH; i++) begin
      m_pend[i] = 0;
      m_act[i]  = 0;
    end
    m_p = 0;
    m_mode = 0;
    m_build();
    exp_pwm = '0;
    exp_ps  = 1'b0;
  endtask

  function automatic int m_cur();
    return en ? m_seq[m_idx] : 0;
  endfunction

  task automatic m_update();
    int cur;
    cur = m_cur();
    for (int i = 0; i < NCH; i++)
      exp_pwm[i] = en ? ((cur < m_act[i]) ^ polarity[i]) : polarity[i];
    exp_ps = en && (cur == 0);
    if (bus.wr_en && (int'(bus.wr_ch) < NCH)) m_pend[bus.wr_ch] = int'(bus.wr_duty);
    if (!en || (m_idx + 1 >= m_seq.size())) begin
      for (int i = 0; i < NCH; i++) m_act[i] = m_pend[i];
      m_p    = int'(period);
      m_mode = int'(mode);
      m_build();
    end else begin
      m_idx++;
    end
  endtask

  task automatic tick();
    @(posedge clk);
    m_update();
    @(negedge clk);
  endtask

  task automatic do_write(input int ch, input int duty);
    bus.wr_en   = 1'b1;
    bus.wr_ch   = 4'(ch);
    bus.wr_duty = 8'(duty);
    tick();
    bus.wr_en   = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    m_reset();
    @(negedge clk);
    n_tests++;
    if (pwm_out !== '0 || period_start !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_state: pwm_out=%b period_start=%b, expected 0 0", pwm_out, period_start);
    end
    rst_n = 1'b1;
    for (int k = 0; k < 3; k++) begin
      tick();
      n_tests++;
      if (pwm_out !== exp_pwm || period_start !== exp_ps) begin
        n_fail++;
        $display("FAIL reset_idle: pwm_out=%b ps=%b, expected %b %b", pwm_out, period_start, exp_pwm, exp_ps);
      end
    end
  endtask

  task automatic test_edge();
    int hi [4];
    int want [4];
    int ps_cnt;
    int guard;
    want = '{3, 0, 10, 10};
    for (int c = 0; c < 4; c++) hi[c] = 0;
    ps_cnt = 0;
    en = 1'b0; mode = 1'b0; period = 8'd9; polarity = '0;
    do_write(0, 3); do_write(1, 0); do_write(2, 10); do_write(3, 255);
    tick();
    en = 1'b1;
    guard = 0;
    do begin
      tick();
      guard++;
      n_tests++;
      if (pwm_out !== exp_pwm || period_start !== exp_ps) begin
        n_fail++;
        $display("FAIL edge_cycle: pwm_out=%b ps=%b, expected %b %b", pwm_out, period_start, exp_pwm, exp_ps);
      end
    end while (period_start !== 1'b1 && guard < 20);
    for (int k = 0; k < 10; k++) begin
      if (k > 0) begin
        tick();
        n_tests++;
        if (pwm_out !== exp_pwm || period_start !== exp_ps) begin
          n_fail++;
          $display("FAIL edge_cycle: pwm_out=%b ps=%b, expected %b %b", pwm_out, period_start, exp_pwm, exp_ps);
        end
      end
      for (int c = 0; c < 4; c++) hi[c] += int'(pwm_out[c]);
      ps_cnt += int'(period_start);
    end
    for (int c = 0; c < 4; c++) begin
      n_tests++;
      if (hi[c] !== want[c]) begin
        n_fail++;
        $display("FAIL edge_high_ch%0d: got %0d high cycles, expected %0d", c, hi[c], want[c]);
      end
    end
    n_tests++;
    if (ps_cnt !== 1) begin
      n_fail++;
      $display("FAIL edge_period_start: got %0d pulses in 10 cycles, expected 1", ps_cnt);
    end
  endtask

  task automatic test_center();
    int hi [5];
    int want [5];
    int guard;
    want = '{0, 1, 5, 7, 8};
    for (int c = 0; c < 5; c++) hi[c] = 0;
    en = 1'b0; mode = 1'b1; period = 8'd4;
    do_write(0, 0); do_write(1, 1); do_write(2, 3); do_write(3, 4); do_write(4, 5);
    en = 1'b1;
    guard = 0;
    do begin
      tick();
      guard++;
      n_tests++;
      if (pwm_out !== exp_pwm || period_start !== exp_ps) begin
        n_fail++;
        $display("FAIL center_cycle: pwm_out=%b ps=%b, expected %b %b", pwm_out, period_start, exp_pwm, exp_ps);
      end
    end while (period_start !== 1'b1 && guard < 20);
    for (int k = 0; k < 16; k++) begin
      if (k > 0) begin
        tick();
        n_tests++;
        if (pwm_out !== exp_pwm || period_start !== exp_ps) begin
          n_fail++;
          $display("FAIL center_cycle: pwm_out=%b ps=%b, expected %b %b", pwm_out, period_start, exp_pwm, exp_ps);
        end
      end
      if (k < 8) for (int c = 0; c < 5; c++) hi[c] += int'(pwm_out[c]);
      if (k == 8) begin
        n_tests++;
        if (period_start !== 1'b1) begin
          n_fail++;
          $display("FAIL center_period_len: period_start=%b at cycle 8, expected 1", period_start);
        end
      end
    end
    for (int c = 0; c < 5; c++) begin
      n_tests++;
      if (hi[c] !== want[c]) begin
        n_fail++;
        $display("FAIL center_high_ch%0d: got %0d high cycles, expected %0d", c, hi[c], want[c]);
      end
    end
  endtask

  // Runs until the model counter reaches target, then applies one write.
  task automatic write_at_cnt(input int target, input int ch, input int duty, input string tag);
    int guard;
    guard = 0;
    while (m_cur() != target && guard < 40) begin
      tick();
      guard++;
      n_tests++;
      if (pwm_out !== exp_pwm || period_start !== exp_ps) begin
        n_fail++;
        $display("FAIL %s_cycle: pwm_out=%b ps=%b, expected %b %b", tag, pwm_out, period_start, exp_pwm, exp_ps);
      end
    end
    if (guard >= 40) begin
      n_fail++;
      $display("FAIL %s_timeout: counter %0d never reached, expected %0d", tag, m_cur(), target);
    end
    do_write(ch, duty);
  endtask

  task automatic run_period_count(input int ch, input int want, input string tag);
    int guard;
    int hi;
    guard = 0;
    hi = 0;
    do begin
      tick();
      guard++;
      n_tests++;
      if (pwm_out !== exp_pwm || period_start !== exp_ps) begin
        n_fail++;
        $display("FAIL %s_cycle: pwm_out=%b ps=%b, expected %b %b", tag, pwm_out, period_start, exp_pwm, exp_ps);
      end
    end while (period_start !== 1'b1 && guard < 20);
    for (int k = 0; k < 10; k++) begin
      if (k > 0) begin
        tick();
        n_tests++;
        if (pwm_out !== exp_pwm || period_start !== exp_ps) begin
          n_fail++;
          $display("FAIL %s_cycle: pwm_out=%b ps=%b, expected %b %b", tag, pwm_out, period_start, exp_pwm, exp_ps);
        end
      end
      hi += int'(pwm_out[ch]);
    end
    n_tests++;
    if (hi !== want) begin
      n_fail++;
      $display("FAIL %s_high: got %0d high cycles, expected %0d", tag, hi, want);
    end
  endtask

  task automatic test_mid_write();
    en = 1'b0; mode = 1'b0; period = 8'd9; polarity = '0;
    do_write(0, 2);
    en = 1'b1;
    tick();
    write_at_cnt(3, 0, 7, "midwrite");
    run_period_count(0, 7, "midwrite_next");
  endtask

  task automatic test_bad_and_load_write();
    en = 1'b0;
    for (int ch = 9; ch < 16; ch++) do_write(ch, 1 + ch);
    en = 1'b1;
    for (int k = 0; k < 12; k++) begin
      tick();
      n_tests++;
      if (pwm_out !== exp_pwm || period_start !== exp_ps) begin
        n_fail++;
        $display("FAIL bad_ch: pwm_out=%b ps=%b, expected %b %b", pwm_out, period_start, exp_pwm, exp_ps);
      end
    end
    write_at_cnt(9, 0, 5, "loadwrite");
    n_tests++;
    if (period_start !== 1'b0) begin
      n_fail++;
      $display("FAIL loadwrite_phase: period_start=%b, expected 0", period_start);
    end
    run_period_count(0, 5, "loadwrite_next");
  endtask

  task automatic test_period_change_and_disable();
    int guard;
    int gap;
    write_at_cnt(4, 1, 0, "pchange");
    period = 8'd4;
    guard = 0;
    do begin
      tick();
      guard++;
      n_tests++;
      if (pwm_out !== exp_pwm || period_start !== exp_ps) begin
        n_fail++;
        $display("FAIL pchange_cycle: pwm_out=%b ps=%b, expected %b %b", pwm_out, period_start, exp_pwm, exp_ps);
      end
    end while (period_start !== 1'b1 && guard < 20);
    for (int rep = 0; rep < 2; rep++) begin
      gap = 0;
      do begin
        tick();
        gap++;
        n_tests++;
        if (pwm_out !== exp_pwm || period_start !== exp_ps) begin
          n_fail++;
          $display("FAIL pchange_cycle: pwm_out=%b ps=%b, expected %b %b", pwm_out, period_start, exp_pwm, exp_ps);
        end
      end while (period_start !== 1'b1 && gap < 20);
      n_tests++;
      if (gap !== 5) begin
        n_fail++;
        $display("FAIL pchange_len: got period %0d cycles, expected 5", gap);
      end
    end
    write_at_cnt(2, 2, 0, "disable");
    en = 1'b0;
    polarity = 9'h001;
    for (int k = 0; k < 3; k++) begin
      tick();
      n_tests++;
      if (pwm_out !== 9'h001 || period_start !== 1'b0 || pwm_out !== exp_pwm) begin
        n_fail++;
        $display("FAIL disable_out: pwm_out=%b ps=%b, expected %b 0", pwm_out, period_start, 9'h001);
      end
    end
    polarity = '0;
  endtask

  task automatic test_async_reset();
    en = 1'b0; mode = 1'b0; period = 8'd6;
    do_write(0, 4); do_write(1, 6);
    en = 1'b1;
    write_at_cnt(3, 2, 3, "areset");
    #2 rst_n = 1'b0;
    #1;
    n_tests++;
    if (pwm_out !== '0 || period_start !== 1'b0) begin
      n_fail++;
      $display("FAIL areset_async: pwm_out=%b ps=%b, expected 0 0", pwm_out, period_start);
    end
    m_reset();
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < 6; k++) begin
      tick();
      n_tests++;
      if (pwm_out !== '0 || (k == 0 && period_start !== 1'b1) ||
          pwm_out !== exp_pwm || period_start !== exp_ps) begin
        n_fail++;
        $display("FAIL areset_restart: pwm_out=%b ps=%b, expected %b %b", pwm_out, period_start, exp_pwm, exp_ps);
      end
    end
  endtask

  task automatic test_random();
    for (int k = 0; k < 1500; k++) begin
      bus.wr_en   = ($urandom_range(0, 9) < 3);
      bus.wr_ch   = 4'($urandom_range(0, 15));
      bus.wr_duty = ($urandom_range(0, 9) == 0) ? 8'd255 : 8'($urandom_range(0, 14));
      if ($urandom_range(0, 19) == 0) period = 8'($urandom_range(0, 12));
      if ($urandom_range(0, 19) == 0) mode = ~mode;
      if ($urandom_range(0, 19) == 0) polarity = NCH'($urandom);
      if ($urandom_range(0, 29) == 0) en = ~en;
      else if (!en && $urandom_range(0, 3) == 0) en = 1'b1;
      tick();
      n_tests++;
      if (pwm_out !== exp_pwm || period_start !== exp_ps) begin
        n_fail++;
        $display("FAIL random_%0d: pwm_out=%b ps=%b, expected %b %b", k, pwm_out, period_start, exp_pwm, exp_ps);
      end
    end
    bus.wr_en = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL timeout: simulation exceeded time budget");
    $fatal(1, "timeout");
  end

  initial begin
    bus.wr_en   = 1'b0;
    bus.wr_ch   = '0;
    bus.wr_duty = '0;
    test_reset();
    test_edge();
    test_center();
    test_mid_write();
    test_bad_and_load_write();
    test_period_change_and_disable();
    test_async_reset();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
`default_nettype wire

// File: doc/pwm_multi.md
# pwm_multi

Parametrised multi-channel PWM generator: NCH channels share one RES-bit counter with a programmable period. It supports edge-aligned and center-aligned modes, per-channel output polarity, and double-buffered duty registers that take effect only at period boundaries, so outputs never glitch. It sits between the register/config interface, which writes duty values one channel at a time, and the output pads or motor/LED drivers.

## Interface
- NCH, 9: channel count, 1..32
- RES, 16: counter, period and duty width, 2..32
- clk  in  1  clock, all logic on rising edge
- rst_n  in  1  asynchronous, active-low reset
- en  in  1  run enable; 0 holds the counter at 0 and outputs at the inactive level
- mode  in  1  0 = edge-aligned, 1 = center-aligned; sampled at load cycles only
- period  in  RES  period value P; sampled at load cycles only
- wr_en  in  1  duty write strobe, one cycle per write
- wr_ch  in  max(1,$clog2(NCH))  target channel of a write
- wr_duty  in  RES  duty value written to that channel's pending register
- polarity  in  NCH  per-channel output inversion, applied live (not buffered)
- pwm_out  out  NCH  registered PWM outputs
- period_start  out  1  registered one-cycle pulse marking the first cycle of each period

## Operation
- **State**
  - cnt: RES bits
  - dir: up/down, center mode only
  - P_act, mode_act: active period and mode
  - pend[NCH], act[NCH]: pending and active duty, RES bits each
- **Writes**
  - wr_en=1 with wr_ch<NCH: pend[wr_ch] <= wr_duty.
  - wr_ch>=NCH: write ignored, no state change.
- **Load cycle**: any cycle where en=0, or where the next value of cnt is 0.
  - Updates: act[i] <= pend[i], P_act <= period, mode_act <= mode.
  - A write in the same cycle is forwarded: act[wr_ch] takes wr_duty directly.
- **en=0**
  - cnt <= 0, dir <= up.
  - Load occurs every cycle.
  - pwm_out[i] <= polarity[i]; period_start <= 0.
- **Edge mode (mode_act=0)**
  - Count sequence 0,1,…,P_act, then back to 0; period length P_act+1 cycles.
  - Channel is high while cnt < act[i], giving min(act[i], P_act+1) high cycles per period.
- **Center mode (mode_act=1)**
  - Counting up: cnt==P_act gives dir<=down, cnt<=P_act-1; otherwise cnt+1.
  - Counting down: cnt==1 gives cnt<=0, dir<=up; otherwise cnt-1.
  - Sequence for P_act=3: 0,1,2,3,2,1 (period 2·P_act cycles).
  - Same compare (cnt < act[i]). High cycles: 0 if D=0, 2D-1 for 1<=D<=P_act, 2·P_act for D>P_act.
- **P_act=0**: cnt stays 0 in both modes and load occurs every cycle.
  - act[i]=0 gives a constant low raw output; any nonzero act[i] gives constant high.
- **Output and pulse**
  - pwm_out[i] <= (cnt < act[i]) ^ polarity[i], with inactive level = polarity[i].
  - period_start <= en && (cnt==0).
- **Width rules**
  - All compares are unsigned RES-bit.
  - The counter never exceeds P_act, so no wrap past 2^RES-1 occurs.
  - P=2^RES-1 in edge mode gives 2^RES cycles.
- **Mid-period changes**: changing period or mode mid-period has no effect until the next load cycle.

## Timing
- **Reset values**
  - cnt=0, dir=up, P_act=0, mode_act=0, all pend/act=0.
  - pwm_out=0, period_start=0.
- pwm_out and period_start lag cnt by 1 cycle.
- **Write latency**: a write reaches pwm_out at the first period_start after the next load cycle.
  - Worst case: one full period plus 1 cycle.
  - Best case, write in the load cycle: visible with the next period_start.
- **en rising**: cnt=0 in the cycle en is first seen high. The first period_start and pwm_out appear 1 cycle later, using values loaded during en=0.
- **en falling**: pwm_out goes to polarity one cycle after en=0 is sampled, mid-period included.
- **Reset mid-operation**: all outputs go to reset values immediately (asynchronous). Operation restarts from cnt=0 after release.
- **polarity**: affects pwm_out on the next clock, with no period alignment.

## Test plan
- Edge mode, RES=8, P=9, act[0]=3, act[1]=0, act[2]=10, act[3]=255, polarity=0 -> per 10-cycle period: ch0 high 3 cycles starting at period_start, ch1 always low, ch2 and ch3 always high; period_start every 10 cycles.
- Center mode, P=4, duties 0/1/3/4/5 on ch0..4 -> period 8 cycles; high counts 0/1/5/7/8, each centered on cnt==0.
- Write duty 2→7 on ch0 at cnt=3 with P=9 -> current period keeps 2 high cycles; the next period has 7; no runt or extended pulse.
- Write wr_ch=9 (NCH=9) -> no channel changes. Write on ch0 in the load cycle (cnt==P) -> new duty takes effect in the immediately following period.
- P changed 9→4 mid-period, then en dropped mid-period with polarity[0]=1 -> the 10-cycle period completes before 5-cycle periods begin; after en=0, pwm_out[0]=1, the others 0, and period_start stays 0.
- Assert rst_n low mid-period -> pwm_out=0 and period_start=0 asynchronously. After release with en=1, the first period_start comes 1 cycle after the first enabled clock, and all duties read 0 (outputs low).
